// File: rtl/ov5640_sccb_config_seq.sv
// Walks the OV5640 register table and issues one SCCB write per entry to the shared i2c_master.
// Handles skip entries, the end marker, the post-soft-reset delay and bounded NACK retries.
module ov5640_sccb_config_seq #(
   parameter int unsigned POWERUP_CYCLES   = 1_000_000,
   parameter int unsigned RST_DELAY_CYCLES = 250_000,
   parameter int unsigned RST_DELAY_INDEX  = 1,
   parameter int unsigned MAX_RETRY        = 3,
   parameter int unsigned MAX_ENTRIES      = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_start,
   output logic [9:0]  lut_index,
   input  logic [31:0] lut_data,
   output logic        i2c_write_req,
   output logic [7:0]  i2c_slave_addr,
   output logic [15:0] i2c_addr,
   output logic [7:0]  i2c_data,
   input  logic        i2c_done,
   input  logic        i2c_error,
   output logic        cfg_busy,
   output logic        cfg_done,
   output logic        cfg_error
);

   localparam int unsigned MAX_DLY = (POWERUP_CYCLES > RST_DELAY_CYCLES) ? POWERUP_CYCLES
                                                                         : RST_DELAY_CYCLES;
   localparam int CNT_W   = $clog2(MAX_DLY + 1);
   localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [CNT_W-1:0]   PWR_LAST   = CNT_W'(POWERUP_CYCLES - 1);
   localparam logic [CNT_W-1:0]   RST_LAST   = CNT_W'(RST_DELAY_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
   localparam logic [9:0]         IDX_DELAY  = 10'(RST_DELAY_INDEX);
   localparam logic [9:0]         IDX_LAST   = 10'(MAX_ENTRIES);

   typedef enum logic [2:0] {
      PWRUP, FETCH, DECODE, ISSUE, WAIT, DELAY, DONE, ERROR
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   dly_cnt;
   logic [RETRY_W-1:0] retry_cnt;
   logic               last_entry;

   // The index never wraps: the ceiling entry finishes the sequence instead of advancing.
   assign last_entry = (lut_index == IDX_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= PWRUP;
         lut_index      <= '0;
         i2c_write_req  <= 1'b0;
         i2c_slave_addr <= '0;
         i2c_addr       <= '0;
         i2c_data       <= '0;
         cfg_busy       <= 1'b1;
         cfg_done       <= 1'b0;
         cfg_error      <= 1'b0;
         retry_cnt      <= '0;
         dly_cnt        <= '0;
      end else begin
         case (state)
            PWRUP: begin
               if (dly_cnt == PWR_LAST) begin
                  dly_cnt <= '0;
                  state   <= FETCH;
               end else begin
                  dly_cnt <= dly_cnt + 1'b1;
               end
            end
            FETCH: state <= DECODE;
            DECODE: begin
               if (lut_data[31:24] == 8'hFF) begin
                  cfg_busy <= 1'b0;
                  cfg_done <= 1'b1;
                  state    <= DONE;
               end else if (lut_data[31:24] == 8'h00) begin
                  if (last_entry) begin
                     cfg_busy <= 1'b0;
                     cfg_done <= 1'b1;
                     state    <= DONE;
                  end else begin
                     lut_index <= lut_index + 10'd1;
                     state     <= FETCH;
                  end
               end else begin
                  i2c_slave_addr <= lut_data[31:24];
                  i2c_addr       <= lut_data[23:8];
                  i2c_data       <= lut_data[7:0];
                  retry_cnt      <= '0;
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
               i2c_write_req <= 1'b1;
               state         <= WAIT;
            end
            WAIT: begin
               if (i2c_done) begin
                  i2c_write_req <= 1'b0;
                  if (!i2c_error) begin
                     if (lut_index == IDX_DELAY) begin
                        dly_cnt <= '0;
                        state   <= DELAY;
                     end else if (last_entry) begin
                        cfg_busy <= 1'b0;
                        cfg_done <= 1'b1;
                        state    <= DONE;
                     end else begin
                        lut_index <= lut_index + 10'd1;
                        state     <= FETCH;
                     end
                  end else if (retry_cnt < RETRY_MAX) begin
                     // Going back through ISSUE guarantees req is low for a cycle between attempts.
                     retry_cnt <= retry_cnt + 1'b1;
                     state     <= ISSUE;
                  end else begin
                     cfg_busy  <= 1'b0;
                     cfg_error <= 1'b1;
                     state     <= ERROR;
                  end
               end
            end
            DELAY: begin
               if (dly_cnt == RST_LAST) begin
                  dly_cnt <= '0;
                  if (last_entry) begin
                     cfg_busy <= 1'b0;
                     cfg_done <= 1'b1;
                     state    <= DONE;
                  end else begin
                     lut_index <= lut_index + 10'd1;
                     state     <= FETCH;
                  end
               end else begin
                  dly_cnt <= dly_cnt + 1'b1;
               end
            end
            DONE, ERROR: begin
               if (cfg_start) begin
                  lut_index <= '0;
                  cfg_busy  <= 1'b1;
                  cfg_done  <= 1'b0;
                  cfg_error <= 1'b0;
                  retry_cnt <= '0;
                  dly_cnt   <= '0;
                  state     <= PWRUP;
               end
            end
            default: state <= PWRUP;
         endcase
      end
   end

endmodule

// File: tb/tb_ov5640_sccb_config_seq.sv
// Directed bench: synthetic register table, behavioural i2c_master responder with NACK injection.
module tb_ov5640_sccb_config_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_start = 1'b0;
   logic [9:0]  lut_index;
   logic [31:0] lut_data;
   logic        i2c_write_req;
   logic [7:0]  i2c_slave_addr;
   logic [15:0] i2c_addr;
   logic [7:0]  i2c_data;
   logic        i2c_done = 1'b0;
   logic        i2c_error = 1'b0;
   logic        cfg_busy, cfg_done, cfg_error;

   int vec = 0;
   int miss = 0;
   int cyc = 0;
   bit no_end = 1'b0;

   // responder / monitor state
   int nack_index = -1;
   int nack_left = 0;
   int writes = 0;
   int reqs5 = 0;
   int bus_err = 0;
   int skip_seen = 0;
   int max_gap = 0;
   int gap2 = 0;
   int last_done_cyc = 0;
   int last_req_idx = -10;
   bit active = 1'b0;
   int act_cnt = 0;
   logic [31:0] held;

   ov5640_sccb_config_seq #(
      .POWERUP_CYCLES(10), .RST_DELAY_CYCLES(50), .RST_DELAY_INDEX(1),
      .MAX_RETRY(3), .MAX_ENTRIES(1023)
   ) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .lut_index(lut_index), .lut_data(lut_data),
      .i2c_write_req(i2c_write_req), .i2c_slave_addr(i2c_slave_addr), .i2c_addr(i2c_addr),
      .i2c_data(i2c_data), .i2c_done(i2c_done), .i2c_error(i2c_error),
      .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] tbl(input logic [9:0] i, input bit ne);
      if (i == 10'd0) return {8'h78, 16'h3103, 8'h11};
      if (i == 10'd1) return {8'h78, 16'h3008, 8'h82};
      if (i == 10'd5) return {8'h78, 16'h3018, 8'hFF};
      if (i >= 10'd208 && i <= 10'd210) return 32'h0000_0000;
      if (i == 10'd257 && !ne) return 32'hFF00_0000;
      return {8'h78, 16'h4000 + {6'd0, i}, i[7:0]};
   endfunction

   assign lut_data = tbl(lut_index, no_end);

   // i2c_master model: done pulse 5 cycles after req is seen, optional NACK on one entry
   initial begin
      forever begin
         @(negedge clk);
         i2c_done  = 1'b0;
         i2c_error = 1'b0;
         if (rst) begin
            active = 1'b0;
         end else if (active) begin
            if ({i2c_slave_addr, i2c_addr, i2c_data} !== held || !i2c_write_req) bus_err++;
            act_cnt++;
            if (act_cnt == 5) begin
               i2c_done = 1'b1;
               if (int'(lut_index) == nack_index && nack_left > 0) begin
                  i2c_error = 1'b1;
                  nack_left--;
               end
               active = 1'b0;
               last_done_cyc = cyc;
            end
         end else if (i2c_write_req) begin
            active  = 1'b1;
            act_cnt = 0;
            held    = {i2c_slave_addr, i2c_addr, i2c_data};
            writes++;
            if (lut_index == 10'd5) reqs5++;
            if (i2c_slave_addr == 8'h00 || (lut_index >= 10'd208 && lut_index <= 10'd210)) skip_seen++;
            if (held !== tbl(lut_index, no_end)) bus_err++;
            if (int'(lut_index) == last_req_idx + 1) begin
               if (lut_index == 10'd2) gap2 = cyc - last_done_cyc;
               else if (cyc - last_done_cyc > max_gap) max_gap = cyc - last_done_cyc;
            end
            last_req_idx = int'(lut_index);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      writes = 0; reqs5 = 0; bus_err = 0; skip_seen = 0;
      max_gap = 0; gap2 = 0; last_req_idx = -10;
   endtask

   task automatic release_and_time(input string tag);
      int n;
      @(negedge clk);
      rst = 1'b0;
      clear_stats();
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!i2c_write_req && n < 100);
      check({tag, "_latency"}, n, 13);
      check({tag, "_slave"}, i2c_slave_addr, 8'h78);
      check({tag, "_addr"}, i2c_addr, 16'h3103);
      check({tag, "_data"}, i2c_data, 8'h11);
   endtask

   task automatic wait_end(input string tag, input int bound);
      int n = 0;
      while (!(cfg_done || cfg_error) && n < bound) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_no_timeout"}, n < bound, 1);
   endtask

   task automatic wait_req_at(input string tag, input logic [9:0] idx);
      int n = 0;
      while (!(i2c_write_req && lut_index == idx) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_reached"}, n < 5000, 1);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
   endtask

   task automatic check_full_run(input string tag, input int exp_writes);
      check({tag, "_done"}, cfg_done, 1);
      check({tag, "_busy"}, cfg_busy, 0);
      check({tag, "_error"}, cfg_error, 0);
      check({tag, "_index"}, lut_index, 257);
      check({tag, "_writes"}, writes, exp_writes);
      check({tag, "_skips"}, skip_seen, 0);
      check({tag, "_bus"}, bus_err, 0);
      check({tag, "_req_low"}, i2c_write_req, 0);
   endtask

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_index", lut_index, 0);
      check("rst_req", i2c_write_req, 0);
      check("rst_slave", i2c_slave_addr, 0);
      check("rst_addr", i2c_addr, 0);
      check("rst_data", i2c_data, 0);
      check("rst_busy", cfg_busy, 1);
      check("rst_done", cfg_done, 0);
      check("rst_err", cfg_error, 0);

      // first write latency and full table walk with the soft-reset delay
      release_and_time("t1");
      wait_end("t2", 10000);
      check_full_run("t2", 254);
      check("t3_reset_gap", gap2 >= 50, 1);
      check("t3_other_gaps", max_gap <= 4 && max_gap > 0, 1);

      // rerun from DONE with entry 5 NACKed twice; cfg_start mid-run ignored
      nack_index = 5;
      nack_left  = 2;
      clear_stats();
      @(negedge clk);
      cfg_start = 1'b1;
      @(posedge clk);
      #1;
      check("t6_restart_busy", cfg_busy, 1);
      check("t6_restart_done", cfg_done, 0);
      check("t6_restart_index", lut_index, 0);
      @(negedge clk);
      cfg_start = 1'b0;
      wait_req_at("t6_busy_start", 10'd50);
      pulse_start();
      check("t6_busy_start_index", lut_index, 50);
      check("t6_busy_start_busy", cfg_busy, 1);
      wait_end("t4", 10000);
      check_full_run("t4", 256);
      check("t4_reqs_entry5", reqs5, 3);

      // entry 5 always NACKed: four attempts then ERROR
      nack_left = 1000;
      clear_stats();
      pulse_start();
      wait_end("t5", 10000);
      check("t5_error", cfg_error, 1);
      check("t5_busy", cfg_busy, 0);
      check("t5_done", cfg_done, 0);
      check("t5_index", lut_index, 5);
      check("t5_reqs_entry5", reqs5, 4);
      check("t5_req_low", i2c_write_req, 0);

      // restart from ERROR, then async reset while waiting on entry 100
      nack_index = -1;
      nack_left  = 0;
      pulse_start();
      check("t6_err_cleared", cfg_error, 0);
      wait_req_at("t6_rst_point", 10'd100);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_req", i2c_write_req, 0);
      check("t6_rst_index", lut_index, 0);
      check("t6_rst_busy", cfg_busy, 1);
      repeat (3) @(negedge clk);
      release_and_time("t6");
      wait_end("t6_run", 10000);
      check_full_run("t6_run", 254);
      check("t6_reset_gap", gap2 >= 50, 1);

      // no end marker: the index ceiling ends the sequence without wrapping
      no_end = 1'b1;
      clear_stats();
      pulse_start();
      wait_end("ceil", 30000);
      check("ceil_done", cfg_done, 1);
      check("ceil_busy", cfg_busy, 0);
      check("ceil_index", lut_index, 1023);
      check("ceil_writes", writes, 1021);
      check("ceil_bus", bus_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
